fifo_wr_arbiter: RTL

Round-robin write-port arbiter that shares one `fifo` write port (wr_en/wr_data/full) among NREQ producers. Each producer has a valid/ready handshake. The arbiter grants one producer at a time, for a burst of up to MAX_BURST words, then rotates to the next. It sits directly in front of the `fifo` instance and never issues a write while the FIFO reports full.

---
 rtl/fifo_wr_arbiter_pkg.sv | 14 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 33 +++
 rtl/fifo_wr_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port round-robin arbiter.
package fifo_wr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Index width for an n-entry vector; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotate-priority encoder: first set request at or above i_ptr, wrapping at NREQ.
module fifo_wr_arbiter_rr_pick
    import fifo_wr_arbiter_pkg::*;
#(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IDXW = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDXW-1:0] i_ptr,
    output logic            o_any,
    output logic [IDXW-1:0] o_idx
);

    int cand;

    // Scan from the farthest offset down so the nearest request to i_ptr wins.
    always_comb begin
        o_any = 1'b0;
        o_idx = '0;
        cand  = 0;
        for (int off = int'(NREQ) - 1; off >= 0; off--) begin
            cand = int'(i_ptr) + off;
            if (cand >= int'(NREQ)) begin
                cand = cand - int'(NREQ);
            end
            if (i_req[IDXW'(cand)]) begin
                o_any = 1'b1;
                o_idx = IDXW'(cand);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ valid/ready producers,
// granting bursts of up to MAX_BURST words before rotating.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter  int unsigned NREQ      = 4,
    parameter  int unsigned DATAW     = 8,
    parameter  int unsigned MAX_BURST = 4,
    localparam int unsigned IDXW      = idx_width(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       i_req_valid,
    input  logic [NREQ*DATAW-1:0] i_req_data,
    output logic [NREQ-1:0]       o_req_ready,
    input  logic                  i_fifo_full,
    output logic                  o_fifo_wr_en,
    output logic [DATAW-1:0]      o_fifo_wr_data,
    output logic [NREQ-1:0]       o_grant,
    output logic [IDXW-1:0]       o_grant_id
);

    localparam int unsigned CNTW = $clog2(MAX_BURST + 1);

    arb_state_e      state_q, state_d;
    logic [IDXW-1:0] grant_id_q, grant_id_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic            holder_valid_c;
    logic            xfer_c;
    logic            release_c;
    logic [IDXW-1:0] ptr_inc_c;
    logic [IDXW-1:0] pick_ptr_c;
    logic            pick_any_c;
    logic [IDXW-1:0] pick_idx_c;

    // Write path is combinational off the grant register; reset blocks it immediately.
    assign holder_valid_c = i_req_valid[grant_id_q];
    assign xfer_c         = (state_q == ST_GRANT) & holder_valid_c & ~i_fifo_full & ~rst;
    assign o_fifo_wr_en   = xfer_c;
    assign o_req_ready    = xfer_c ? (NREQ'(1) << grant_id_q) : '0;
    assign o_fifo_wr_data = xfer_c ? i_req_data[int'(grant_id_q) * DATAW +: DATAW] : '0;

    assign ptr_inc_c  = (grant_id_q == IDXW'(NREQ - 1)) ? '0 : grant_id_q + IDXW'(1);
    assign release_c  = (state_q == ST_GRANT) &
                        ((xfer_c & (cnt_q == CNTW'(MAX_BURST - 1))) | ~holder_valid_c);
    // On release the new pointer takes effect in the same-edge pick.
    assign pick_ptr_c = (state_q == ST_GRANT) ? ptr_inc_c : ptr_q;

    fifo_wr_arbiter_rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .i_req (i_req_valid),
        .i_ptr (pick_ptr_c),
        .o_any (pick_any_c),
        .o_idx (pick_idx_c)
    );

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any_c) begin
                    state_d    = ST_GRANT;
                    grant_id_d = pick_idx_c;
                    cnt_d      = '0;
                end
            end
            ST_GRANT: begin
                if (release_c) begin
                    ptr_d = ptr_inc_c;
                    cnt_d = '0;
                    if (pick_any_c) begin
                        grant_id_d = pick_idx_c;
                    end else begin
                        state_d    = ST_IDLE;
                        grant_id_d = '0;
                    end
                end else if (xfer_c) begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                grant_id_d = '0;
                cnt_d      = '0;
            end
        endcase
        grant_d = (state_d == ST_GRANT) ? (NREQ'(1) << grant_id_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            grant_id_q <= '0;
            grant_q    <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign o_grant    = grant_q;
    assign o_grant_id = grant_id_q;

endmodule
